aes_round_pipe: RTL and testbench



---
 rtl/aes_round_pipe.sv | 218 +++++++++++++++++++++
 tb/tb_aes_round_pipe.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_pipe.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_pipe
// Purpose  : Pipelined AES encryption round with AddRoundKey. Each
//            transaction computes either a full round
//            (MixColumns(ShiftRows(SubBytes(s))) ^ key) or, when last is set,
//            the final round without MixColumns. 1..3 register stages with
//            valid/ready handshaking and bubble-collapsing backpressure.
// Ports    : clk, rst_n (async, active-low), flush (sync clear)
//            in_valid/in_ready/in_state/in_key/in_last/in_tag  - input side
//            out_valid/out_ready/out_state/out_tag             - output side
//            occupancy - number of valid stages
// Revision : 1.0 - initial release
// ============================================================================
module aes_round_pipe #(
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       in_state,
    input  logic [127:0]       in_key,
    input  logic               in_last,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       out_state,
    output logic [TAG_W-1:0]   out_tag,
    output logic [1:0]         occupancy
);

    localparam int NS = PIPE_STAGES;
    // ShiftRows shares stage 0 with SubBytes unless there are three stages.
    localparam int SR_AT = (NS <= 2) ? 0 : 1;

    // ------------------------------------------------------------------
    // GF(2^8) helpers and round primitives (byte 0 at [127:120])
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // Multiplicative inverse as b^254 (square-and-multiply over 11111110b);
    // 0 maps to 0 naturally. Followed by the AES affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gf_mul(inv, inv);
            if (i != 0) inv = gf_mul(inv, b);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [15:0][7:0] b;
        logic [15:0][7:0] o;
        b = s;
        for (int i = 0; i < 16; i++) o[i] = sbox(b[i]);
        return o;
    endfunction

    // Row r of column c takes the byte from column (c + r) mod 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [15:0][7:0] b;
        logic [15:0][7:0] o;
        b = s;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[15 - (r + 4 * c)] = b[15 - (r + 4 * ((c + r) % 4))];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [15:0][7:0] b;
        logic [15:0][7:0] o;
        logic [7:0]       a0, a1, a2, a3;
        b = s;
        for (int c = 0; c < 4; c++) begin
            a0 = b[15 - 4 * c];
            a1 = b[14 - 4 * c];
            a2 = b[13 - 4 * c];
            a3 = b[12 - 4 * c];
            o[15 - 4 * c] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
            o[14 - 4 * c] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
            o[13 - 4 * c] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
            o[12 - 4 * c] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // ------------------------------------------------------------------
    // Handshake: a stage loads when it is empty or its content moves on.
    // Collapsing that recursion gives load[k] = any stage k..end empty, or
    // out_ready. This is a pure combinational path from out_ready.
    // ------------------------------------------------------------------
    logic [NS-1:0]      w_valid;
    logic [NS-1:0]      w_load;
    logic [127:0]       w_data [NS];
    logic [TAG_W-1:0]   w_tag  [NS];
    logic [1:0]         w_occ;

    always_comb begin
        logic w_chain;
        w_load  = '0;
        w_chain = !w_valid[NS-1] | out_ready;
        w_load[NS-1] = w_chain;
        for (int k = NS - 2; k >= 0; k--) begin
            w_chain   = !w_valid[k] | w_chain;
            w_load[k] = w_chain;
        end
    end

    assign in_ready = w_load[0] & !flush;

    always_comb begin
        w_occ = '0;
        for (int k = 0; k < NS; k++) w_occ = w_occ + {1'b0, w_valid[k]};
    end

    assign occupancy = w_occ;
    assign out_valid = w_valid[NS-1];
    assign out_state = w_data[NS-1];
    assign out_tag   = w_tag[NS-1];

    // ------------------------------------------------------------------
    // Stages
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NS; k++) begin : g_stage
        logic               w_src_valid;
        logic [127:0]       w_src_data;
        logic [127:0]       w_src_key;
        logic               w_src_last;
        logic [TAG_W-1:0]   w_src_tag;
        logic [127:0]       w_sb;
        logic [127:0]       w_sr;
        logic [127:0]       w_next;
        logic               r_valid;
        logic [127:0]       r_data;
        logic [TAG_W-1:0]   r_tag;

        if (k == 0) begin : g_src_in
            assign w_src_valid = in_valid & in_ready;
            assign w_src_data  = in_state;
            assign w_src_key   = in_key;
            assign w_src_last  = in_last;
            assign w_src_tag   = in_tag;
        end else begin : g_src_prev
            assign w_src_valid = w_valid[k-1];
            assign w_src_data  = w_data[k-1];
            assign w_src_key   = g_stage[k-1].g_carry.r_key;
            assign w_src_last  = g_stage[k-1].g_carry.r_last;
            assign w_src_tag   = w_tag[k-1];
        end

        assign w_sb   = (k == 0)     ? sub_bytes(w_src_data) : w_src_data;
        assign w_sr   = (k == SR_AT) ? shift_rows(w_sb)      : w_sb;
        // AddRoundKey is folded into the output stage, so the key and last
        // flag are only held by the stages in front of it.
        assign w_next = (k == NS - 1)
                      ? ((w_src_last ? w_sr : mix_columns(w_sr)) ^ w_src_key)
                      : w_sr;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_data  <= '0;
                r_tag   <= '0;
            end else if (flush) begin
                r_valid <= 1'b0;
            end else if (w_load[k]) begin
                r_valid <= w_src_valid;
                if (w_src_valid) begin
                    r_data <= w_next;
                    r_tag  <= w_src_tag;
                end
            end
        end

        if (k < NS - 1) begin : g_carry
            logic [127:0] r_key;
            logic         r_last;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_key  <= '0;
                    r_last <= 1'b0;
                end else if (!flush && w_load[k] && w_src_valid) begin
                    r_key  <= w_src_key;
                    r_last <= w_src_last;
                end
            end
        end

        assign w_valid[k] = r_valid;
        assign w_data[k]  = r_data;
        assign w_tag[k]   = r_tag;
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_round_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_round_pipe
// Purpose  : Self-checking bench driving three aes_round_pipe instances
//            (PIPE_STAGES 1, 2, 3) against a transaction-level reference
//            model built from the AES round definition.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_round_pipe;

    localparam int ND = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush;
    logic         in_valid  [ND];
    logic         in_ready  [ND];
    logic [127:0] in_state  [ND];
    logic [127:0] in_key    [ND];
    logic         in_last   [ND];
    logic [3:0]   in_tag    [ND];
    logic         out_valid [ND];
    logic         out_ready [ND];
    logic [127:0] out_state [ND];
    logic [3:0]   out_tag   [ND];
    logic [1:0]   occupancy [ND];

    always #5 clk = ~clk;

    for (genvar d = 0; d < ND; d++) begin : g_dut
        aes_round_pipe #(.PIPE_STAGES(d + 1), .TAG_W(4)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .in_valid  (in_valid[d]),
            .in_ready  (in_ready[d]),
            .in_state  (in_state[d]),
            .in_key    (in_key[d]),
            .in_last   (in_last[d]),
            .in_tag    (in_tag[d]),
            .out_valid (out_valid[d]),
            .out_ready (out_ready[d]),
            .out_state (out_state[d]),
            .out_tag   (out_tag[d]),
            .occupancy (occupancy[d])
        );
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: per DUT, an ordered list (oldest first) of in-flight
    // transactions with their pipeline position and expected result.
    logic [7:0]   sbt [256];
    int           m_cnt [ND];
    int           m_pos [ND][3];
    logic [127:0] m_res [ND][3];
    logic [3:0]   m_tag [ND][3];
    int           accepts [ND];
    int           pops [ND];
    int           first_pop [ND];
    int           last_pop [ND];
    bit           was_stalled [ND];
    logic [127:0] prev_state [ND];
    logic [3:0]   prev_tag [ND];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: brute-force inverse, then per-bit affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                     ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            sbt[x] = s;
        end
    endtask

    function automatic logic [127:0] round_ref(input logic [127:0] st,
                                               input logic [127:0] key,
                                               input logic last);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   m [4][4];
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = st[127 - 8 * (r + 4 * c) -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r][c] = sbt[s[r][(c + r) % 4]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = last ? t[r][c]
                        : gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r + 1) % 4][c])
                          ^ t[(r + 2) % 4][c] ^ t[(r + 3) % 4][c];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8 * (r + 4 * c) -: 8] = m[r][c];
        return o ^ key;
    endfunction

    task automatic chk(input string name, input int d,
                       input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s P=%0d observed=%h expected=%h", name, d + 1, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic [3:0] tag);
        in_valid[d] = v;
        in_state[d] = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_key[d]   = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_last[d]  = 1'($urandom_range(0, 1));
        in_tag[d]   = tag;
    endtask

    task automatic model_clear();
        for (int d = 0; d < ND; d++) begin
            m_cnt[d] = 0;
            was_stalled[d] = 1'b0;
        end
    endtask

    // One clock: check the settled outputs against the model, then advance
    // the model across the rising edge. Called and returns at a falling edge.
    task automatic tick();
        bit acc [ND];
        bit pop [ND];
        #1;
        for (int d = 0; d < ND; d++) begin
            int  p;
            bit  exp_ready;
            bit  exp_ov;
            p = d + 1;
            exp_ready = !flush && (m_cnt[d] < p || out_ready[d]);
            exp_ov    = m_cnt[d] > 0 && m_pos[d][0] == p - 1;
            chk("in_ready", d, 128'(in_ready[d]), 128'(exp_ready));
            chk("out_valid", d, 128'(out_valid[d]), 128'(exp_ov));
            chk("occupancy", d, 128'(occupancy[d]), 128'(m_cnt[d]));
            if (exp_ov) begin
                chk("out_state", d, out_state[d], m_res[d][0]);
                chk("out_tag", d, 128'(out_tag[d]), 128'(m_tag[d][0]));
            end
            if (was_stalled[d]) begin
                chk("stall_state", d, out_state[d], prev_state[d]);
                chk("stall_tag", d, 128'(out_tag[d]), 128'(prev_tag[d]));
            end
            acc[d] = in_valid[d] && exp_ready;
            pop[d] = exp_ov && out_ready[d];
            was_stalled[d] = exp_ov && !out_ready[d] && !flush;
            prev_state[d]  = out_state[d];
            prev_tag[d]    = out_tag[d];
        end
        @(posedge clk);
        for (int d = 0; d < ND; d++) begin
            int p;
            p = d + 1;
            if (flush) begin
                m_cnt[d] = 0;
            end else begin
                if (pop[d]) begin
                    for (int i = 0; i < m_cnt[d] - 1; i++) begin
                        m_pos[d][i] = m_pos[d][i + 1];
                        m_res[d][i] = m_res[d][i + 1];
                        m_tag[d][i] = m_tag[d][i + 1];
                    end
                    m_cnt[d]--;
                    if (pops[d] == 0) first_pop[d] = cyc;
                    last_pop[d] = cyc;
                    pops[d]++;
                end
                for (int i = 0; i < m_cnt[d]; i++) begin
                    int lim;
                    lim = (i == 0) ? p : m_pos[d][i - 1];
                    if (m_pos[d][i] + 1 < lim) m_pos[d][i]++;
                end
                if (acc[d]) begin
                    m_pos[d][m_cnt[d]] = 0;
                    m_res[d][m_cnt[d]] = round_ref(in_state[d], in_key[d], in_last[d]);
                    m_tag[d][m_cnt[d]] = in_tag[d];
                    m_cnt[d]++;
                    accepts[d]++;
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_counts();
        for (int d = 0; d < ND; d++) begin
            accepts[d] = 0;
            pops[d] = 0;
            first_pop[d] = 0;
            last_pop[d] = 0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        flush = 1'b0;
        for (int d = 0; d < ND; d++) begin
            in_valid[d] = 1'b0; in_state[d] = '0; in_key[d] = '0;
            in_last[d] = 1'b0; in_tag[d] = '0; out_ready[d] = 1'b0;
        end
        model_clear();
        clear_counts();
        build_sbox();

        // Reset state
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk("rst_out_valid", d, 128'(out_valid[d]), 128'(0));
            chk("rst_out_state", d, out_state[d], 128'h0);
            chk("rst_out_tag", d, 128'(out_tag[d]), 128'(0));
            chk("rst_occupancy", d, 128'(occupancy[d]), 128'(0));
        end
        rst_n = 1'b1;
        tick();

        // FIPS-197 round 1, then final round
        for (int v = 0; v < 2; v++) begin
            for (int d = 0; d < ND; d++) begin
                in_valid[d]  = 1'b1;
                in_state[d]  = (v == 0) ? 128'h193de3bea0f4e22b9ac68d2ae9f84808
                                        : 128'heb40f21e592e38848ba113e71bc342d2;
                in_key[d]    = (v == 0) ? 128'ha0fafe1788542cb123a339392a6c7605
                                        : 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
                in_last[d]   = (v == 1);
                in_tag[d]    = 4'd3;
                out_ready[d] = 1'b1;
            end
            tick();
            for (int d = 0; d < ND; d++) in_valid[d] = 1'b0;
            tick();
            #1;
            chk("fips_valid", 1, 128'(out_valid[1]), 128'(1));
            chk("fips_state", 1, out_state[1],
                (v == 0) ? 128'ha49c7ff2689f352b6b5bea43026a5049
                         : 128'h3925841d02dc09fbdc118597196a0b32);
            chk("fips_tag", 1, 128'(out_tag[1]), 128'(3));
            repeat (3) tick();
        end

        // Backpressure: 8 tagged transactions per DUT, random out_ready
        clear_counts();
        for (int n = 0; n < 400; n++) begin
            bit done;
            done = 1'b1;
            for (int d = 0; d < ND; d++) begin
                drive(d, accepts[d] < 8 && $urandom_range(0, 3) != 0, 4'(accepts[d]));
                out_ready[d] = 1'($urandom_range(0, 1));
            end
            tick();
            for (int d = 0; d < ND; d++)
                if (accepts[d] < 8 || m_cnt[d] != 0) done = 1'b0;
            if (done) break;
        end
        for (int d = 0; d < ND; d++) chk("bp_pops", d, 128'(pops[d]), 128'(8));

        // Full throughput: 16 back-to-back transactions
        clear_counts();
        for (int d = 0; d < ND; d++) out_ready[d] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            for (int d = 0; d < ND; d++) drive(d, 1'b1, 4'(i));
            tick();
        end
        for (int d = 0; d < ND; d++) in_valid[d] = 1'b0;
        repeat (4) tick();
        for (int d = 0; d < ND; d++) begin
            chk("tp_pops", d, 128'(pops[d]), 128'(16));
            chk("tp_consecutive", d, 128'(last_pop[d] - first_pop[d]), 128'(15));
        end

        // Flush with every pipeline full
        for (int d = 0; d < ND; d++) out_ready[d] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int d = 0; d < ND; d++) drive(d, 1'b1, 4'(8 + i));
            tick();
        end
        flush = 1'b1;
        for (int d = 0; d < ND; d++) drive(d, 1'b1, 4'hf);
        tick();
        flush = 1'b0;
        for (int d = 0; d < ND; d++) begin
            in_valid[d] = 1'b0;
            out_ready[d] = 1'b1;
        end
        #1;
        for (int d = 0; d < ND; d++) begin
            chk("flush_occ", d, 128'(occupancy[d]), 128'(0));
            chk("flush_valid", d, 128'(out_valid[d]), 128'(0));
        end
        repeat (4) tick();

        // Asynchronous reset with transactions in flight
        for (int d = 0; d < ND; d++) out_ready[d] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int d = 0; d < ND; d++) drive(d, 1'b1, 4'(i + 1));
            tick();
        end
        for (int d = 0; d < ND; d++) in_valid[d] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            chk("arst_valid", d, 128'(out_valid[d]), 128'(0));
            chk("arst_state", d, out_state[d], 128'h0);
            chk("arst_occ", d, 128'(occupancy[d]), 128'(0));
        end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < ND; d++) begin
            drive(d, 1'b1, 4'h9);
            out_ready[d] = 1'b1;
        end
        clear_counts();
        tick();
        for (int d = 0; d < ND; d++) in_valid[d] = 1'b0;
        repeat (4) tick();
        for (int d = 0; d < ND; d++) chk("arst_new_pop", d, 128'(pops[d]), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
